fir_cmem_dbuf: RTL
==================

Name: fir_cmem_dbuf

Overview:
- Parametrised, double-banked coefficient memory for the FIR datapath. Generalises the single-bank, fixed 65-tap FP16 coefficient load path.
- The host writes a new coefficient set into the shadow bank while the MAC reads the active bank.
- A requested bank swap takes effect only on a sample-frame boundary, so a filter pass never mixes old and new coefficients.
- Sits between the coefficient loader and the FIR MAC sequencer.

Parameters:
- NTAPS, 65, number of coefficients per bank (taps).
- DW, 16, coefficient word width (FP16 by default).
- AW, 7, address width; must satisfy 2^AW >= NTAPS.
- EXP_MSB, 14, MSB of the exponent field within a coefficient word.
- EXP_LSB, 10, LSB of the exponent field within a coefficient word.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  coefficient write strobe.
- wr_addr  in  AW  coefficient write address (tap index).
- wr_data  in  DW  coefficient write data.
- swap_req  in  1  request to promote the shadow bank to active.
- frame_start  in  1  one-cycle strobe marking a sample-frame boundary (already synchronous to clk).
- rd_en  in  1  MAC read strobe.
- rd_addr  in  AW  MAC read address (tap index).
- rd_data  out  DW  registered read data.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- active_bank  out  1  index of the bank currently read by the MAC.
- swap_pending  out  1  swap requested but not yet applied.
- wr_err  out  1  one-cycle pulse: write rejected.
- load_cnt  out  AW+1  accepted writes since the last swap.
- denorm_cnt  out  8  denormal coefficients seen since reset.

Behaviour:
- Reset (rst=1 at a clk edge):
  - active_bank=0, swap_pending=0, rd_data=0, rd_valid=0, wr_err=0, load_cnt=0, denorm_cnt=0.
  - Memory array is not cleared; the bench checks only written locations.
  - Reset mid-operation aborts any pending swap.
- Storage: 2 x NTAPS words of DW bits. Bank b occupies entries b*NTAPS .. b*NTAPS+NTAPS-1.
- Write acceptance: wr_en=1 AND wr_addr<NTAPS AND swap_pending=0 AND no swap applied in that same cycle.
- Accepted write:
  - Data goes to the shadow bank (~active_bank) at wr_addr.
  - load_cnt increments, saturating at 2^(AW+1)-1.
- Rejected write:
  - Applies when wr_en=1 and any acceptance condition fails.
  - Nothing is stored; wr_err=1 for the next cycle only.
- Swap state machine, two states:
  - IDLE: swap_req=1 & frame_start=0 -> PEND (swap_pending=1). swap_req=1 & frame_start=1 -> apply the swap that same edge, stay IDLE.
  - PEND: frame_start=1 -> apply the swap, go to IDLE. Further swap_req in PEND has no effect; there is no double toggle.
  - Applying a swap toggles active_bank, clears load_cnt and clears swap_pending at the same edge.
- Read path:
  - rd_en=1 samples rd_addr and the current active_bank.
  - rd_data is registered: latency 1 cycle, with rd_valid=1 in that cycle.
  - If rd_addr>=NTAPS, rd_data=0 with rd_valid=1.
  - A read issued in the swap cycle returns the pre-swap active bank.
  - With rd_en=0, rd_valid=0 and rd_data holds its previous value.
- Simultaneous write and read at the same index cannot collide: writes target only the shadow bank and reads only the active bank.
- Denormal detection:
  - An accepted word is denormal when wr_data[EXP_MSB:EXP_LSB]==0 and its mantissa bits wr_data[EXP_LSB-1:0] are non-zero.
  - denorm_cnt increments per denormal word, saturating at 255.

Optional Feature:
- Macro: FIR_CMEM_DENORM_FLUSH_EN.
- Defined: an accepted word with exponent field 0 is stored as signed zero, {wr_data[DW-1], (DW-1) zeros}. denorm_cnt counts as described above.
- Not defined: words are stored verbatim and denorm_cnt is tied to 0.

Test Plan:
- Reset, then write taps 0..64 with data {6'b001111, addr}. Pulse swap_req, then frame_start 10 cycles later -> swap_pending=1 until the frame_start edge, then active_bank=1 and load_cnt=0. Read all 65 taps -> each returns its written value one cycle after rd_en.
- Write to wr_addr=65 and wr_addr=127 -> wr_err pulses 1 cycle each, load_cnt unchanged, a read of tap 0 is unchanged. Read rd_addr=100 -> rd_data=0, rd_valid=1.
- Assert swap_req (frame_start low), then attempt a write -> wr_err=1 and the shadow location unchanged. Assert frame_start -> active_bank toggles and a subsequent write is accepted.
- swap_req and frame_start in the same cycle while in IDLE -> active_bank toggles at that edge, swap_pending never rises. An rd_en issued in that cycle returns the old-bank value.
- With FIR_CMEM_DENORM_FLUSH_EN defined, write 16'h0003 and 16'h8001 -> after swap both read 16'h0000 and 16'h8000, denorm_cnt=2. Without the macro -> both read verbatim and denorm_cnt=0.
- Write 10 taps, assert rst for 1 cycle mid-stream with swap pending -> all outputs return to reset values, active_bank=0, swap_pending=0.

Source files
------------

// File: rtl/fir_cmem_dbuf_if.sv
// Bus bundle between coefficient loader / MAC sequencer and the coefficient memory.
// Latency: n/a (wires only); rd_data/rd_valid come back one cycle after rd_en.
// Backpressure: none on reads; writes are refused with a wr_err pulse, never stalled.
interface fir_cmem_dbuf_if #(
    parameter int AW = 7,
    parameter int DW = 16
);
    // Loader side
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          frame_start;
    // MAC side
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    // Status
    logic          active_bank;
    logic          swap_pending;
    logic          wr_err;
    logic [AW:0]   load_cnt;
    logic [7:0]    denorm_cnt;

    // Driver of writes, swap control and reads
    modport master (
        output wr_en, wr_addr, wr_data, swap_req, frame_start, rd_en, rd_addr,
        input  rd_data, rd_valid, active_bank, swap_pending, wr_err, load_cnt, denorm_cnt
    );

    // The coefficient memory itself
    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, frame_start, rd_en, rd_addr,
        output rd_data, rd_valid, active_bank, swap_pending, wr_err, load_cnt, denorm_cnt
    );
endinterface

// File: rtl/fir_cmem_dbuf.sv
// Double-banked FIR coefficient memory: host fills the shadow bank, swap on frame boundary.
// Latency: 1 cycle read (rd_en -> rd_data/rd_valid); writes land on the next edge.
// Backpressure: writes refused (wr_err pulse) while a swap is pending/applying; reads never stall.
// Optional build macro FIR_CMEM_DENORM_FLUSH_EN: flush zero-exponent words to signed zero and count denormals.
module fir_cmem_dbuf #(
    parameter int NTAPS   = 65,
    parameter int DW      = 16,
    parameter int AW      = 7,
    parameter int EXP_MSB = 14,
    parameter int EXP_LSB = 10
) (
    input  logic             clk,
    input  logic             rst,
    fir_cmem_dbuf_if.slave   cm
);

    localparam int          IW       = AW + 1;
    localparam logic [AW:0] NTAPS_W  = IW'(NTAPS);
    localparam logic [AW:0] LOAD_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } swap_state_t;

    swap_state_t   state_q;
    swap_state_t   state_d;
    logic          swap_apply;

    logic          active_q;
    logic [AW:0]   load_q;
    logic          wr_err_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;

    // Both banks in one array: bank b lives at b*NTAPS .. b*NTAPS+NTAPS-1.
    logic [DW-1:0] mem [0:2*NTAPS-1];

    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_accept;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] wr_word;

    logic          exp_zero;
    logic          mant_nz;
    logic          is_denorm;

    assign wr_in_range = ({1'b0, cm.wr_addr} < NTAPS_W);
    assign rd_in_range = ({1'b0, cm.rd_addr} < NTAPS_W);

    // A write in the swap cycle would land in a bank that is becoming active, so it is refused.
    assign wr_accept = cm.wr_en & wr_in_range & (state_q == S_IDLE) & ~swap_apply;

    // Writes target the shadow bank, reads the active bank: the two can never alias.
    assign wr_idx = active_q ? {1'b0, cm.wr_addr} : (NTAPS_W + {1'b0, cm.wr_addr});
    assign rd_idx = active_q ? (NTAPS_W + {1'b0, cm.rd_addr}) : {1'b0, cm.rd_addr};

    assign exp_zero  = (cm.wr_data[EXP_MSB:EXP_LSB] == '0);
    assign mant_nz   = (cm.wr_data[EXP_LSB-1:0] != '0);
    assign is_denorm = exp_zero & mant_nz;

`ifdef FIR_CMEM_DENORM_FLUSH_EN
    logic [7:0] denorm_q;

    // Zero-exponent words become signed zero so the MAC never sees a subnormal operand.
    assign wr_word = exp_zero ? {cm.wr_data[DW-1], {(DW-1){1'b0}}} : cm.wr_data;

    // Saturating count of accepted denormal words; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            denorm_q <= '0;
        end else if (wr_accept && is_denorm && (denorm_q != 8'hFF)) begin
            denorm_q <= denorm_q + 8'd1;
        end
    end

    assign cm.denorm_cnt = denorm_q;
`else
    logic unused_denorm;

    assign wr_word       = cm.wr_data;
    assign unused_denorm = is_denorm;
    assign cm.denorm_cnt = '0;
`endif

    // Swap FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM: a request waits for the next frame boundary; a request on the boundary applies at once.
    always_comb begin
        state_d    = state_q;
        swap_apply = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cm.swap_req) begin
                    if (cm.frame_start) begin
                        swap_apply = 1'b1;
                    end else begin
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                // Extra swap_req here is ignored: one request, one toggle.
                if (cm.frame_start) begin
                    swap_apply = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Active bank flips only when a swap is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
        end else if (swap_apply) begin
            active_q <= ~active_q;
        end
    end

    // Accepted-write counter for the current shadow fill, cleared by each swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= '0;
        end else if (swap_apply) begin
            load_q <= '0;
        end else if (wr_accept && (load_q != LOAD_MAX)) begin
            load_q <= load_q + 1'b1;
        end
    end

    // One-cycle error pulse for every refused write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= cm.wr_en & ~wr_accept;
        end
    end

    // Coefficient storage; deliberately not reset so a reset does not wipe a loaded set.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= wr_word;
        end
    end

    // Registered read of the bank active at issue time; out-of-range taps read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= cm.rd_en;
            if (cm.rd_en) begin
                rd_data_q <= rd_in_range ? mem[rd_idx] : '0;
            end
        end
    end

    assign cm.rd_data      = rd_data_q;
    assign cm.rd_valid     = rd_valid_q;
    assign cm.active_bank  = active_q;
    assign cm.swap_pending = (state_q == S_PEND);
    assign cm.wr_err       = wr_err_q;
    assign cm.load_cnt     = load_q;

endmodule
